// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader uses the slave view; the stream source and memory model use the master view.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_waddr;
  logic [31:0]           imem_wdata;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  imem_we,
    input  imem_waddr,
    input  imem_wdata
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output imem_we,
    output imem_waddr,
    output imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader: takes a framed byte stream, writes little-endian words into
// instruction memory from address 0, and holds the core in reset until the checksum matches.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         core_reset,
  output logic         busy,
  output logic         done,
  output logic         error
);

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t                state;
  logic [15:0]           n_words;
  logic [16:0]           word_cnt;
  logic [1:0]            byte_cnt;
  logic [7:0]            sum;
  logic [31:0]           word_reg;
  logic                  we_r;
  logic [ADDR_WIDTH-1:0] waddr_r;
  logic [31:0]           wdata_r;
  logic                  accept;
  logic [15:0]           n_full;

  assign accept         = bus.in_valid && busy;
  assign n_full         = {bus.in_data, n_words[7:0]};
  assign bus.in_ready   = busy;
  assign bus.imem_we    = we_r;
  assign bus.imem_waddr = waddr_r;
  assign bus.imem_wdata = wdata_r;

  // busy tracks the next state so in_ready is already high the cycle after start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      n_words    <= '0;
      word_cnt   <= '0;
      byte_cnt   <= '0;
      sum        <= '0;
      word_reg   <= '0;
      we_r       <= 1'b0;
      waddr_r    <= '0;
      wdata_r    <= '0;
      core_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      we_r <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= LEN0;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            core_reset <= 1'b1;
            byte_cnt   <= '0;
            word_cnt   <= '0;
            sum        <= '0;
            word_reg   <= '0;
          end
        end
        LEN0: begin
          if (accept) begin
            n_words[7:0] <= bus.in_data;
            state        <= LEN1;
          end
        end
        LEN1: begin
          if (accept) begin
            n_words[15:8] <= bus.in_data;
            if ({1'b0, n_full} > DEPTH_W) begin
              state <= ERR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else if (n_full == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            sum                             <= sum + bus.in_data;
            word_reg[{byte_cnt, 3'b000} +: 8] <= bus.in_data;
            byte_cnt                        <= byte_cnt + 2'd1;
            // The fourth byte goes straight to the write port, bypassing word_reg.
            if (byte_cnt == 2'd3) begin
              we_r     <= 1'b1;
              waddr_r  <= word_cnt[ADDR_WIDTH-1:0];
              wdata_r  <= {bus.in_data, word_reg[23:0]};
              word_cnt <= word_cnt + 17'd1;
              if (word_cnt + 17'd1 == {1'b0, n_words}) begin
                state <= CSUM;
              end
            end
          end
        end
        CSUM: begin
          if (accept) begin
            busy <= 1'b0;
            if (bus.in_data == sum) begin
              state      <= DONE;
              done       <= 1'b1;
              core_reset <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes are queued as frames are sent,
// and a negedge monitor pops and compares each imem_we pulse.
module tb_imem_loader;

  localparam int AW = 8;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic core_reset;
  logic busy;
  logic done;
  logic error;

  int checks = 0;
  int errors = 0;

  logic [39:0] exp_q[$];
  logic [7:0]  frame[$];

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW), .DEPTH(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Every write strobe must match the oldest outstanding expected word.
  always @(negedge clk) begin : monitor
    logic [39:0] e;
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got addr %0d data 0x%08h expected no write",
                 bus.imem_waddr, bus.imem_wdata);
      end else begin
        e = exp_q.pop_front();
        checkOutput("write_addr", 32'(bus.imem_waddr), {24'd0, e[39:32]});
        checkOutput("write_data", bus.imem_wdata, e[31:0]);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic pushWord(input logic [7:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    int guard;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready stayed %b for byte 0x%02h, expected 1", bus.in_ready, b);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic doStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    checkOutput("ready_after_start", 32'(bus.in_ready), 32'd1);
    checkOutput("core_reset_after_start", 32'(core_reset), 32'd1);
    checkOutput("done_after_start", 32'(done), 32'd0);
    checkOutput("error_after_start", 32'(error), 32'd0);
  endtask

  // Sends the frame queue; done must stay low until the final (checksum) byte is accepted.
  task automatic applyStimulus(input bit gapped);
    int n;
    n = frame.size();
    for (int i = 0; i < n - 1; i++) begin
      sendByte(frame[i], gapped ? 1 + (i % 3) : 0);
    end
    checkOutput("done_before_csum", 32'(done), 32'd0);
    checkOutput("core_reset_before_csum", 32'(core_reset), 32'd1);
    sendByte(frame[n-1], gapped ? 1 + ((n - 1) % 3) : 0);
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] reset and idle");
    checkOutput("idle_waddr", 32'(bus.imem_waddr), 32'd0);
    checkOutput("idle_wdata", bus.imem_wdata, 32'd0);
    for (int c = 0; c < 5; c++) begin
      checkOutput("idle_core_reset", 32'(core_reset), 32'd1);
      checkOutput("idle_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("idle_imem_we", 32'(bus.imem_we), 32'd0);
      checkOutput("idle_done", 32'(done), 32'd0);
      checkOutput("idle_error", 32'(error), 32'd0);
      @(posedge clk);
      #1;
    end

    $display("[TB] two-word load at full rate");
    doStart();
    frame = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h77};
    pushWord(8'd0, 32'h0050_0113);
    pushWord(8'd1, 32'h0000_0013);
    applyStimulus(1'b0);
    checkOutput("load1_done", 32'(done), 32'd1);
    checkOutput("load1_core_reset", 32'(core_reset), 32'd0);
    checkOutput("load1_busy", 32'(busy), 32'd0);
    checkOutput("load1_error", 32'(error), 32'd0);
    checkOutput("load1_writes_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] two-word load with valid gaps");
    doStart();
    pushWord(8'd0, 32'h0050_0113);
    pushWord(8'd1, 32'h0000_0013);
    applyStimulus(1'b1);
    checkOutput("gap_done", 32'(done), 32'd1);
    checkOutput("gap_core_reset", 32'(core_reset), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("gap_writes_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] bad checksum");
    doStart();
    frame[10] = 8'h78;
    pushWord(8'd0, 32'h0050_0113);
    pushWord(8'd1, 32'h0000_0013);
    applyStimulus(1'b0);
    checkOutput("badsum_error", 32'(error), 32'd1);
    checkOutput("badsum_done", 32'(done), 32'd0);
    checkOutput("badsum_core_reset", 32'(core_reset), 32'd1);
    checkOutput("badsum_writes_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("badsum_error_sticky", 32'(error), 32'd1);
    checkOutput("badsum_core_reset_sticky", 32'(core_reset), 32'd1);

    $display("[TB] oversize length");
    doStart();
    sendByte(8'h01, 0);
    sendByte(8'h01, 0);
    checkOutput("oversize_error", 32'(error), 32'd1);
    checkOutput("oversize_busy", 32'(busy), 32'd0);
    checkOutput("oversize_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("oversize_core_reset", 32'(core_reset), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    doStart();
    frame = '{8'h00, 8'h00, 8'h00};
    applyStimulus(1'b0);
    checkOutput("empty_done", 32'(done), 32'd1);
    checkOutput("empty_core_reset", 32'(core_reset), 32'd0);
    checkOutput("empty_error", 32'(error), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] reset mid-frame");
    doStart();
    pushWord(8'd0, 32'h0050_0113);
    frame = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h13, 8'h00};
    foreach (frame[i]) sendByte(frame[i], 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_core_reset", 32'(core_reset), 32'd1);
    checkOutput("midreset_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    checkOutput("midreset_writes_drained", 32'(exp_q.size()), 32'd0);
    doStart();
    frame = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hA3};
    pushWord(8'd0, 32'h0010_0093);
    applyStimulus(1'b0);
    checkOutput("reload_done", 32'(done), 32'd1);
    checkOutput("reload_core_reset", 32'(core_reset), 32'd0);
    checkOutput("reload_writes_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
